alu_issue_arbiter: RTL and testbench

- Shares the single 16-bit ALU between the two issue lanes of the superscalar core.
- Each lane pushes ALU operations into a per-lane FIFO. The arbiter selects one operation per cycle, round-robin, and drives the ALU input bundle from registers.
- It tracks in-flight operations so each ALU result is returned tagged with its originating lane.
- A taken branch flushes all queued and in-flight work.

---
 rtl/alu_issue_arbiter_if.sv | 64 ++++++
 rtl/alu_issue_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_alu_issue_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_arbiter_if.sv
`default_nettype none
// =============================================================================
// Module  : alu_issue_arbiter_if
// Brief   : Lane request, ALU issue bundle and tagged-result signals of the
//           two-lane ALU issue arbiter.
// Rev     : 1.0
// =============================================================================
interface alu_issue_arbiter_if;
    logic        l0_valid;
    logic        l0_ready;
    logic [11:0] l0_alusignals;
    logic [15:0] l0_instr;
    logic [15:0] l0_op1;
    logic [15:0] l0_op2;
    logic [4:0]  l0_immx;
    logic        l0_isimm;

    logic        l1_valid;
    logic        l1_ready;
    logic [11:0] l1_alusignals;
    logic [15:0] l1_instr;
    logic [15:0] l1_op1;
    logic [15:0] l1_op2;
    logic [4:0]  l1_immx;
    logic        l1_isimm;

    logic        flush;

    logic        alu_valid;
    logic [11:0] alu_alusignals;
    logic [15:0] alu_instr;
    logic [15:0] alu_op1;
    logic [15:0] alu_op2;
    logic [4:0]  alu_immx;
    logic        alu_isimm;
    logic [15:0] alu_result;
    logic [15:0] alu_instrout;

    logic        res_valid;
    logic        res_lane;
    logic [15:0] res_data;
    logic [15:0] res_instr;

    // Requesting lanes plus the ALU itself
    modport master (
        output l0_valid, l0_alusignals, l0_instr, l0_op1, l0_op2, l0_immx, l0_isimm,
        output l1_valid, l1_alusignals, l1_instr, l1_op1, l1_op2, l1_immx, l1_isimm,
        output flush, alu_result, alu_instrout,
        input  l0_ready, l1_ready,
        input  alu_valid, alu_alusignals, alu_instr, alu_op1, alu_op2, alu_immx, alu_isimm,
        input  res_valid, res_lane, res_data, res_instr
    );

    // The arbiter
    modport slave (
        input  l0_valid, l0_alusignals, l0_instr, l0_op1, l0_op2, l0_immx, l0_isimm,
        input  l1_valid, l1_alusignals, l1_instr, l1_op1, l1_op2, l1_immx, l1_isimm,
        input  flush, alu_result, alu_instrout,
        output l0_ready, l1_ready,
        output alu_valid, alu_alusignals, alu_instr, alu_op1, alu_op2, alu_immx, alu_isimm,
        output res_valid, res_lane, res_data, res_instr
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_arbiter.sv
`default_nettype none
// =============================================================================
// Module  : alu_issue_arbiter
// Brief   : Round-robin issue of two per-lane op FIFOs onto one shared ALU,
//           with lane tagging of returning results and branch flush.
// Rev     : 1.0
// =============================================================================
module alu_issue_arbiter #(
    parameter int DEPTH   = 2,
    parameter int ALU_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    alu_issue_arbiter_if.slave  bus
);
    localparam int               PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W      = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] C_PTR_ONE  = PTR_W'(1);

    typedef struct packed {
        logic [11:0] alusignals;
        logic [15:0] instr;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [4:0]  immx;
        logic        isimm;
    } op_t;

    op_t        lane_op_w [2];
    op_t        head_w    [2];
    logic [1:0] lane_valid_w;
    logic [1:0] ready_w;
    logic [1:0] push_w;
    logic [1:0] pop_w;
    logic [1:0] nonempty_w;
    logic [1:0] full_w;
    logic       pop_any_w;
    logic       pop_lane_w;

    logic       rr_q,        rr_d;
    op_t        alu_op_q,    alu_op_d;
    logic       alu_valid_q, alu_valid_d;
    logic       alu_lane_q,  alu_lane_d;

    logic [ALU_LAT-1:0] tag_v_q;
    logic [ALU_LAT-1:0] tag_l_q;

    assign lane_op_w[0] = {bus.l0_alusignals, bus.l0_instr, bus.l0_op1,
                           bus.l0_op2, bus.l0_immx, bus.l0_isimm};
    assign lane_op_w[1] = {bus.l1_alusignals, bus.l1_instr, bus.l1_op1,
                           bus.l1_op2, bus.l1_immx, bus.l1_isimm};
    assign lane_valid_w = {bus.l1_valid, bus.l0_valid};

    // Ready looks only at the registered occupancy, so a full FIFO never
    // accepts a push even in the cycle it is being popped.
    assign ready_w = ~full_w & {2{reset & ~bus.flush}};
    assign push_w  = lane_valid_w & ready_w;

    for (genvar l = 0; l < 2; l++) begin : g_lane
        op_t              mem_q [DEPTH];
        logic [PTR_W-1:0] wr_ptr_q;
        logic [PTR_W-1:0] rd_ptr_q;
        logic [CNT_W-1:0] count_q;
        logic [CNT_W-1:0] count_d;

        always_comb begin
            count_d = count_q;
            if (push_w[l] && !pop_w[l]) begin
                count_d = count_q + C_CNT_ONE;
            end else if (!push_w[l] && pop_w[l]) begin
                count_d = count_q - C_CNT_ONE;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else if (bus.flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push_w[l]) begin
                    wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
                end
                if (pop_w[l]) begin
                    rd_ptr_q <= rd_ptr_q + C_PTR_ONE;
                end
                count_q <= count_d;
            end
        end

        // Storage needs no reset: occupancy alone decides what is live.
        always_ff @(posedge clk) begin
            if (push_w[l]) begin
                mem_q[wr_ptr_q] <= lane_op_w[l];
            end
        end

        assign head_w[l]     = mem_q[rd_ptr_q];
        assign nonempty_w[l] = (count_q != '0);
        assign full_w[l]     = (count_q == C_FULL_CNT);
    end

    always_comb begin
        pop_lane_w = rr_q;
        case (nonempty_w)
            2'b01:   pop_lane_w = 1'b0;
            2'b10:   pop_lane_w = 1'b1;
            default: pop_lane_w = rr_q;
        endcase
    end

    assign pop_any_w = (nonempty_w != 2'b00) && !bus.flush;
    assign pop_w     = pop_any_w ? (pop_lane_w ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        rr_d                = rr_q;
        alu_op_d            = alu_op_q;
        alu_op_d.alusignals = '0;
        alu_valid_d         = 1'b0;
        alu_lane_d          = alu_lane_q;
        if (bus.flush) begin
            rr_d = 1'b0;
        end else if (pop_any_w) begin
            rr_d        = ~pop_lane_w;
            alu_op_d    = head_w[pop_lane_w];
            alu_valid_d = 1'b1;
            alu_lane_d  = pop_lane_w;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q        <= 1'b0;
            alu_op_q    <= '0;
            alu_valid_q <= 1'b0;
            alu_lane_q  <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            alu_op_q    <= alu_op_d;
            alu_valid_q <= alu_valid_d;
            alu_lane_q  <= alu_lane_d;
        end
    end

    // Lane tags travel alongside the ALU pipeline; clearing them on flush
    // drops results of ops already handed to the ALU.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_v_q <= '0;
            tag_l_q <= '0;
        end else if (bus.flush) begin
            tag_v_q <= '0;
            tag_l_q <= '0;
        end else begin
            tag_v_q[0] <= alu_valid_q;
            tag_l_q[0] <= alu_lane_q;
            for (int s = 1; s < ALU_LAT; s++) begin
                tag_v_q[s] <= tag_v_q[s-1];
                tag_l_q[s] <= tag_l_q[s-1];
            end
        end
    end

    assign bus.l0_ready       = ready_w[0];
    assign bus.l1_ready       = ready_w[1];
    assign bus.alu_valid      = alu_valid_q;
    assign bus.alu_alusignals = alu_op_q.alusignals;
    assign bus.alu_instr      = alu_op_q.instr;
    assign bus.alu_op1        = alu_op_q.op1;
    assign bus.alu_op2        = alu_op_q.op2;
    assign bus.alu_immx       = alu_op_q.immx;
    assign bus.alu_isimm      = alu_op_q.isimm;
    assign bus.res_valid      = tag_v_q[ALU_LAT-1];
    assign bus.res_lane       = tag_l_q[ALU_LAT-1];
    assign bus.res_data       = bus.alu_result;
    assign bus.res_instr      = bus.alu_instrout;
endmodule
`default_nettype wire

// File: tb/tb_alu_issue_arbiter.sv
`default_nettype none
// =============================================================================
// Module  : tb_alu_issue_arbiter
// Brief   : Self-checking bench for alu_issue_arbiter with a queue-based
//           reference model, a one-cycle ALU model and directed sequences.
// Rev     : 1.0
// =============================================================================
module tb_alu_issue_arbiter;
    localparam int          DEPTH   = 2;
    localparam int          ALU_LAT = 1;
    localparam logic [11:0] C_ADD   = 12'h001;
    localparam logic [11:0] C_SUB   = 12'h008;
    localparam logic [11:0] C_OR    = 12'h080;
    localparam logic [11:0] C_AND   = 12'h100;

    typedef struct packed {
        logic [11:0] alusignals;
        logic [15:0] instr;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [4:0]  immx;
        logic        isimm;
    } op_t;

    typedef struct {
        logic        lane;
        op_t         op;
        logic [15:0] exp_res;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    alu_issue_arbiter_if bus ();

    alu_issue_arbiter #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_ref(input op_t o);
        logic [15:0] b;
        b = o.isimm ? {11'd0, o.immx} : o.op2;
        if (o.alusignals[0])      return o.op1 + b;
        else if (o.alusignals[3]) return o.op1 - b;
        else if (o.alusignals[7]) return o.op1 | b;
        else if (o.alusignals[8]) return o.op1 & b;
        return 16'h0000;
    endfunction

    function automatic op_t mk(input logic [11:0] s, input logic [15:0] ins,
                               input logic [15:0] a, input logic [15:0] b,
                               input logic [4:0] im, input logic isi);
        op_t o;
        o.alusignals = s; o.instr = ins; o.op1 = a; o.op2 = b; o.immx = im; o.isimm = isi;
        return o;
    endfunction

    function automatic op_t rand_op();
        logic [11:0] s;
        case ($urandom_range(0, 3))
            0:       s = C_ADD;
            1:       s = C_SUB;
            2:       s = C_OR;
            default: s = C_AND;
        endcase
        return mk(s, 16'($urandom), 16'($urandom), 16'($urandom), 5'($urandom), 1'($urandom));
    endfunction

    // ALU with one cycle of latency
    always @(posedge clk) begin
        bus.alu_result   <= alu_ref(op_t'({bus.alu_alusignals, bus.alu_instr, bus.alu_op1,
                                           bus.alu_op2, bus.alu_immx, bus.alu_isimm}));
        bus.alu_instrout <= bus.alu_instr;
    end

    // Reference model: per-lane queues, round-robin pointer, issued op, returning tag
    op_t         q0[$];
    op_t         q1[$];
    logic        m_rr, m_v, m_lane, m_tv, m_tl;
    op_t         m_op;
    logic [15:0] m_td, m_ti;
    logic        last_acc0, last_acc1;

    task automatic model_reset();
        q0.delete(); q1.delete();
        m_rr = 1'b0; m_v = 1'b0; m_lane = 1'b0; m_op = '0;
        m_tv = 1'b0; m_tl = 1'b0; m_td = '0; m_ti = '0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v0, input op_t o0, input logic v1, input op_t o1, input logic fl);
        bus.l0_valid = v0; bus.l0_alusignals = o0.alusignals; bus.l0_instr = o0.instr;
        bus.l0_op1 = o0.op1; bus.l0_op2 = o0.op2; bus.l0_immx = o0.immx; bus.l0_isimm = o0.isimm;
        bus.l1_valid = v1; bus.l1_alusignals = o1.alusignals; bus.l1_instr = o1.instr;
        bus.l1_op1 = o1.op1; bus.l1_op2 = o1.op2; bus.l1_immx = o1.immx; bus.l1_isimm = o1.isimm;
        bus.flush = fl;
    endtask

    // One clock: drive, check ready, advance the model, check outputs after the edge.
    task automatic step(input logic v0, input op_t o0, input logic v1, input op_t o1, input logic fl);
        logic r0, r1, n0, n1, pl;
        drive(v0, o0, v1, o1, fl);
        #1;
        r0 = !fl && (q0.size() < DEPTH);
        r1 = !fl && (q1.size() < DEPTH);
        chk("l0_ready", bus.l0_ready, r0);
        chk("l1_ready", bus.l1_ready, r1);
        last_acc0 = v0 && r0;
        last_acc1 = v1 && r1;
        if (fl) begin
            q0.delete(); q1.delete();
            m_v = 1'b0; m_op.alusignals = '0; m_tv = 1'b0; m_rr = 1'b0;
        end else begin
            m_tv = m_v; m_tl = m_lane; m_td = alu_ref(m_op); m_ti = m_op.instr;
            n0 = (q0.size() > 0);
            n1 = (q1.size() > 0);
            pl = (n0 && n1) ? m_rr : n1;
            if (n0 || n1) begin
                if (pl) m_op = q1.pop_front();
                else    m_op = q0.pop_front();
                m_v = 1'b1; m_lane = pl; m_rr = ~pl;
            end else begin
                m_v = 1'b0; m_op.alusignals = '0;
            end
            if (last_acc0) q0.push_back(o0);
            if (last_acc1) q1.push_back(o1);
        end
        @(posedge clk); #1;
        chk("alu_valid", bus.alu_valid, m_v);
        chk("alu_alusignals", bus.alu_alusignals, m_op.alusignals);
        chk("alu_instr", bus.alu_instr, m_op.instr);
        chk("alu_op1", bus.alu_op1, m_op.op1);
        chk("alu_op2", bus.alu_op2, m_op.op2);
        chk("alu_immx", bus.alu_immx, m_op.immx);
        chk("alu_isimm", bus.alu_isimm, m_op.isimm);
        chk("res_valid", bus.res_valid, m_tv);
        if (m_tv) begin
            chk("res_lane", bus.res_lane, m_tl);
            chk("res_data", bus.res_data, m_td);
            chk("res_instr", bus.res_instr, m_ti);
        end
    endtask

    logic [11:0] iss[$];
    int          iss_t[$];
    logic        rl[$];
    logic [15:0] rdat[$];

    task automatic collect(input int cyc);
        if (bus.alu_valid) begin
            iss.push_back(bus.alu_alusignals);
            iss_t.push_back(cyc);
        end
        if (bus.res_valid) begin
            rl.push_back(bus.res_lane);
            rdat.push_back(bus.res_data);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        op_t  z, a, b, c;
        int   a0, a1, cyc;

        z = '0;
        vecs[0] = '{1'b0, mk(C_ADD, 16'h1001, 16'h0003, 16'h0004, 5'h00, 1'b0), 16'h0007};
        vecs[1] = '{1'b0, mk(C_AND, 16'h1002, 16'hF0F0, 16'h0FF0, 5'h00, 1'b0), 16'h00F0};
        vecs[2] = '{1'b1, mk(C_OR,  16'h1003, 16'hF0F0, 16'h0FF0, 5'h00, 1'b0), 16'hFFF0};
        vecs[3] = '{1'b0, mk(C_SUB, 16'h1004, 16'h0010, 16'h0003, 5'h00, 1'b0), 16'h000D};
        vecs[4] = '{1'b0, mk(C_ADD, 16'h1005, 16'h0002, 16'h1234, 5'h01, 1'b1), 16'h0003};
        vecs[5] = '{1'b1, mk(C_ADD, 16'h1006, 16'hFFFF, 16'h0001, 5'h00, 1'b0), 16'h0000};

        // Reset with a lane requesting
        reset = 1'b0;
        drive(1'b1, vecs[0].op, 1'b0, z, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_l0_ready", bus.l0_ready, 0);
        chk("rst_alu_valid", bus.alu_valid, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        bus.l0_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rel_l0_ready", bus.l0_ready, 1);

        // Single-op vectors: 2-cycle issue latency, 1-cycle result latency
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].lane) step(1'b0, z, 1'b1, vecs[i].op, 1'b0);
            else              step(1'b1, vecs[i].op, 1'b0, z, 1'b0);
            chk("vec_early_valid", bus.alu_valid, 0);
            step(1'b0, z, 1'b0, z, 1'b0);
            chk("vec_valid", bus.alu_valid, 1);
            chk("vec_alusig", bus.alu_alusignals, vecs[i].op.alusignals);
            chk("vec_isimm", bus.alu_isimm, vecs[i].op.isimm);
            chk("vec_immx", bus.alu_immx, vecs[i].op.immx);
            step(1'b0, z, 1'b0, z, 1'b0);
            chk("vec_res_valid", bus.res_valid, 1);
            chk("vec_res_lane", bus.res_lane, vecs[i].lane);
            chk("vec_res_data", bus.res_data, vecs[i].exp_res);
        end

        // Round-robin: three ops per lane offered on the same cycles
        step(1'b0, z, 1'b0, z, 1'b1);
        a = mk(C_AND, 16'h2000, 16'hF0F0, 16'h0FF0, 5'h00, 1'b0);
        b = mk(C_OR,  16'h2001, 16'hF0F0, 16'h0FF0, 5'h00, 1'b0);
        a0 = 0; a1 = 0; cyc = 0;
        while ((a0 < 3 || a1 < 3) && cyc < 20) begin
            step(a0 < 3, a, a1 < 3, b, 1'b0);
            if (last_acc0) a0++;
            if (last_acc1) a1++;
            collect(cyc);
            cyc++;
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b0, z, 1'b0, z, 1'b0);
            collect(cyc);
            cyc++;
        end
        chk("rr_issue_count", iss.size(), 6);
        for (int k = 0; k < iss.size() && k < 6; k++)
            chk("rr_order", iss[k], (k % 2) ? C_OR : C_AND);
        if (iss.size() > 0)
            chk("rr_no_bubble", iss_t[iss.size()-1] - iss_t[0], 5);
        chk("rr_res_count", rl.size(), 6);
        for (int k = 0; k < rl.size() && k < 6; k++) begin
            chk("rr_res_lane", rl[k], k % 2);
            chk("rr_res_data", rdat[k], (k % 2) ? 16'hFFF0 : 16'h00F0);
        end

        // Lane1 fills while lane0 holds the grant
        step(1'b0, z, 1'b0, z, 1'b1);
        a = mk(C_ADD, 16'h3000, 16'h0001, 16'h0001, 5'h00, 1'b0);
        b = mk(C_SUB, 16'h3001, 16'h0009, 16'h0001, 5'h00, 1'b0);
        step(1'b1, a, 1'b1, b, 1'b0);
        step(1'b1, a, 1'b1, b, 1'b0);
        chk("full_l1_ready_low", bus.l1_ready, 0);
        step(1'b0, z, 1'b0, z, 1'b0);
        chk("full_l1_pop", bus.alu_alusignals, C_SUB);
        chk("full_l1_ready_back", bus.l1_ready, 1);
        repeat (4) step(1'b0, z, 1'b0, z, 1'b0);

        // Flush with two queued and one in flight
        step(1'b0, z, 1'b0, z, 1'b1);
        c = mk(C_OR, 16'h4002, 16'h00FF, 16'h0100, 5'h00, 1'b0);
        step(1'b1, a, 1'b1, b, 1'b0);
        step(1'b1, c, 1'b0, z, 1'b0);
        chk("fl_inflight", bus.alu_valid, 1);
        step(1'b0, z, 1'b0, z, 1'b1);
        chk("fl_alu_valid", bus.alu_valid, 0);
        chk("fl_res_valid", bus.res_valid, 0);
        chk("fl_ready_low", bus.l0_ready, 0);
        step(1'b0, z, 1'b0, z, 1'b0);
        chk("fl_empty", bus.alu_valid, 0);
        chk("fl_res_still0", bus.res_valid, 0);
        step(1'b1, a, 1'b1, b, 1'b0);
        step(1'b0, z, 1'b0, z, 1'b0);
        chk("fl_lane0_first", bus.alu_alusignals, C_ADD);
        repeat (3) step(1'b0, z, 1'b0, z, 1'b0);

        // Randomized traffic with occasional flushes
        for (int k = 0; k < 400; k++) begin
            a = rand_op();
            b = rand_op();
            step($urandom_range(0, 9) < 6, a, $urandom_range(0, 9) < 6, b,
                 $urandom_range(0, 19) == 0);
        end

        // Reset asserted mid-operation
        repeat (3) step(1'b1, rand_op(), 1'b1, rand_op(), 1'b0);
        reset = 1'b0;
        #1;
        chk("mid_rst_alu_valid", bus.alu_valid, 0);
        chk("mid_rst_res_valid", bus.res_valid, 0);
        chk("mid_rst_l0_ready", bus.l0_ready, 0);
        chk("mid_rst_l1_ready", bus.l1_ready, 0);
        @(posedge clk); #1;
        chk("mid_rst_hold", bus.alu_valid, 0);
        reset = 1'b1;
        model_reset();
        repeat (3) step(1'b0, z, 1'b0, z, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
